// File: rtl/gate_actuator_responder.sv
// Plant-side responder for the gate controller: two timed actuator channels
// with a shared step prescaler. Status, accepts, tick and fault are registered.
module gate_actuator_responder #(
  parameter int TRAVEL   = 8,
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] E,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  output logic [1:0] G1,
  output logic [1:0] G2,
  output logic [1:0] A,
  output logic [1:0] P
);

  localparam int PW = $clog2(TRAVEL + 1);
  localparam int CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_END  = PW'(TRAVEL);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);

  localparam logic [2:0] ST_CLOSED  = 3'd0;
  localparam logic [2:0] ST_OPENING = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_CLOSING = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;
  localparam logic [2:0] ST_NONE    = 3'd7;

  localparam logic [1:0] CMD_OPEN  = 2'b01;
  localparam logic [1:0] CMD_CLOSE = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  logic [1:0]          r_e;
  logic [1:0][1:0]     r_r;
  logic [1:0][1:0]     r_prev;
  logic [CW-1:0]       r_cnt;
  logic [1:0][2:0]     r_st;
  logic [1:0][PW-1:0]  r_pos;
  logic [1:0][1:0]     r_g;
  logic [1:0]          r_a;
  logic [1:0]          r_p;

  logic                w_emg;
  logic                w_run;
  logic                w_tick;
  logic                w_flt_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [1:0][2:0]     w_st_nxt;
  logic [1:0][2:0]     w_tgt;
  logic [1:0][PW-1:0]  w_pos_nxt;
  logic [1:0][PW-1:0]  w_pos_inc;
  logic [1:0]          w_acc;

  // Legal command transitions; ST_NONE means the command is ignored.
  function automatic logic [2:0] cmd_target(input logic [2:0] st, input logic [1:0] cmd);
    logic [2:0] t;
    t = ST_NONE;
    case (st)
      ST_CLOSED:  t = (cmd == CMD_OPEN)  ? ST_OPENING : ST_NONE;
      ST_OPEN:    t = (cmd == CMD_CLOSE) ? ST_CLOSING : ST_NONE;
      ST_OPENING: t = (cmd == CMD_CLOSE) ? ST_CLOSING : ((cmd == CMD_STOP) ? ST_HALTED : ST_NONE);
      ST_CLOSING: t = (cmd == CMD_OPEN)  ? ST_OPENING : ((cmd == CMD_STOP) ? ST_HALTED : ST_NONE);
      ST_HALTED:  t = (cmd == CMD_OPEN)  ? ST_OPENING : ((cmd == CMD_CLOSE) ? ST_CLOSING : ST_NONE);
      default:    t = ST_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] g_code(input logic [2:0] st);
    logic [1:0] g;
    case (st)
      ST_CLOSED:               g = 2'b00;
      ST_OPENING, ST_CLOSING:  g = 2'b01;
      ST_OPEN:                 g = 2'b10;
      default:                 g = 2'b11;
    endcase
    return g;
  endfunction

  // Prescaler, per-channel next state and fault flag
  always_comb begin
    w_emg  = (r_e == 2'b11);
    w_run  = (r_e != 2'b01) && !w_emg;
    w_tick = w_run && (r_cnt == CNT_LAST);
    if (!w_run) begin
      w_cnt_nxt = r_cnt;
    end else if (w_tick) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    for (int i = 0; i < 2; i++) begin
      w_st_nxt[i]  = r_st[i];
      w_pos_nxt[i] = r_pos[i];
      w_pos_inc[i] = r_pos[i] + 1'b1;
      w_acc[i]     = 1'b0;
      w_tgt[i]     = (r_r[i] != r_prev[i]) ? cmd_target(r_st[i], r_r[i]) : ST_NONE;
      if (r_st[i] > ST_HALTED) begin
        w_st_nxt[i]  = ST_CLOSED;
        w_pos_nxt[i] = '0;
      end else if (w_emg) begin
        if (r_st[i] == ST_OPENING || r_st[i] == ST_CLOSING || r_st[i] == ST_OPEN) begin
          w_st_nxt[i] = ST_HALTED;
        end else begin
          w_st_nxt[i] = r_st[i];
        end
      end else if (!w_run) begin
        w_st_nxt[i] = r_st[i];
      end else if (w_tgt[i] != ST_NONE) begin
        // An accepted command wins over the step tick on the same cycle.
        w_st_nxt[i] = w_tgt[i];
        w_acc[i]    = 1'b1;
      end else if (w_tick && r_st[i] == ST_OPENING) begin
        if (r_pos[i] >= POS_END) begin
          w_pos_nxt[i] = POS_END;
          w_st_nxt[i]  = ST_OPEN;
        end else begin
          w_pos_nxt[i] = w_pos_inc[i];
          w_st_nxt[i]  = (w_pos_inc[i] == POS_END) ? ST_OPEN : ST_OPENING;
        end
      end else if (w_tick && r_st[i] == ST_CLOSING) begin
        if (r_pos[i] <= POS_ONE) begin
          w_pos_nxt[i] = '0;
          w_st_nxt[i]  = ST_CLOSED;
        end else begin
          w_pos_nxt[i] = r_pos[i] - 1'b1;
          w_st_nxt[i]  = ST_CLOSING;
        end
      end else begin
        w_st_nxt[i] = r_st[i];
      end
    end

    if (w_emg) begin
      w_flt_nxt = 1'b1;
    end else if (r_st[0] == ST_CLOSED && r_st[1] == ST_CLOSED) begin
      w_flt_nxt = 1'b0;
    end else begin
      w_flt_nxt = r_p[1];
    end
  end

  // Input sampling, command history, channel state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e    <= 2'b00;
      r_r    <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
      r_st   <= '0;
      r_pos  <= '0;
      r_g    <= '0;
      r_a    <= 2'b00;
      r_p    <= 2'b00;
    end else begin
      r_e    <= E;
      r_r    <= {R2, R1};
      r_prev <= r_r;
      r_cnt  <= w_cnt_nxt;
      r_st   <= w_st_nxt;
      r_pos  <= w_pos_nxt;
      r_g    <= {g_code(w_st_nxt[1]), g_code(w_st_nxt[0])};
      r_a    <= w_acc;
      r_p    <= {w_flt_nxt, w_tick};
    end
  end

  assign G1 = r_g[0];
  assign G2 = r_g[1];
  assign A  = r_a;
  assign P  = r_p;

endmodule
